cpu_step_ctrl: RTL

//   Board-level execution controller for the multi-cycle RISC-V CPU. Turns raw push-buttons into
//   a one-cycle CPU clock-enable (single step or free run) and a held CPU reset. Halts on a PC

---
 rtl/cpu_step_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//   Board-level execution controller for the multi-cycle RISC-V CPU. Turns
//   bouncy push-buttons into a one-cycle CPU clock enable (single step or free
//   run) and a held CPU reset. Halts on a PC breakpoint and counts issued steps.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high block reset
//   btn_step     in   1      raw single-step button (async, bouncy)
//   btn_run      in   1      raw run/stop toggle button (async, bouncy)
//   btn_cpu_rst  in   1      raw CPU-reset button (async, bouncy)
//   bp_en        in   1      breakpoint enable
//   bp_addr      in   32     breakpoint PC
//   pc_i         in   32     current CPU PC
//   cpu_ce       out  1      one-cycle CPU clock enable, registered
//   cpu_rst      out  1      CPU reset, registered
//   running      out  1      high while in RUN
//   halted_bp    out  1      high while in BREAK
//   step_cnt     out  CNT_W  cpu_ce pulses since the last CPU reset
//   ctrl_state   out  3      RESET=0 IDLE=1 STEP=2 RUN=3 BREAK=4
//
// There is no valid/ready handshake here: buttons are level inputs and cpu_ce
// is a fire-and-forget strobe that the CPU must act on in the cycle it is high.
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int DB_CYCLES = 20,
    parameter int RUN_DIV   = 4,
    parameter int RST_HOLD  = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             btn_cpu_rst,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc_i,
    output logic             cpu_ce,
    output logic             cpu_rst,
    output logic             running,
    output logic             halted_bp,
    output logic [CNT_W-1:0] step_cnt,
    output logic [2:0]       ctrl_state
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_STEP  = 3'd2,
        S_RUN   = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam int DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int PH_W   = $clog2(RUN_DIV);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(RUN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_VAL = HOLD_W'(RST_HOLD);

    // Button index: 0 = step, 1 = run, 2 = cpu reset
    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db_lvl;
    logic [2:0]      r_db_lvl_d;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      w_press;

    assign w_btn_raw = {btn_cpu_rst, btn_run, btn_step};

    // Debounced level only moves after DB_CYCLES consecutive cycles of a
    // differing synchronised level; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db_lvl   <= '0;
            r_db_lvl_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_btn_raw;
            r_sync2    <= r_sync1;
            r_db_lvl_d <= r_db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_db_lvl[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db_lvl[i] <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle pulse on the debounced rising edge only
    assign w_press = r_db_lvl & ~r_db_lvl_d;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic [PH_W-1:0]   w_phase_inc;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_bp_mask;
    logic              w_mask_nxt;
    logic              r_cpu_ce;
    logic              w_ce_nxt;
    logic              r_cpu_rst;
    logic              w_rst_nxt;
    logic              w_cnt_clr;
    logic [CNT_W-1:0]  r_step_cnt;
    logic              w_pc_eq;
    logic              w_bp_hit;

    assign w_pc_eq     = (pc_i == bp_addr);
    assign w_bp_hit    = bp_en & w_pc_eq & ~r_bp_mask;
    assign w_phase_inc = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

    // cpu_ce and cpu_rst are registered, so the decision for a pulse is made
    // in the cycle before it appears: the next state and its pulse are
    // resolved together, which lets a breakpoint swallow the pulse cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_hold_nxt  = r_hold;
        w_mask_nxt  = r_bp_mask & w_pc_eq;   // mask drops once the PC moves off
        w_ce_nxt    = 1'b0;
        w_rst_nxt   = 1'b0;
        w_cnt_clr   = 1'b0;

        if (w_press[2]) begin
            // CPU reset wins over everything, in every state
            w_state_nxt = S_RESET;
            w_hold_nxt  = HOLD_VAL;
            w_rst_nxt   = 1'b1;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_hold > HOLD_W'(1)) begin
                        w_hold_nxt = r_hold - 1'b1;
                        w_rst_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_press[1]) begin
                        w_phase_nxt = '0;
                        if (w_bp_hit) begin
                            w_state_nxt = S_BREAK;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_ce_nxt    = 1'b1;
                        end
                    end else if (w_press[0]) begin
                        w_state_nxt = S_STEP;
                        w_ce_nxt    = 1'b1;
                    end
                end
                S_STEP: begin
                    w_state_nxt = S_IDLE;
                end
                S_RUN: begin
                    if (w_press[1]) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_phase_nxt = w_phase_inc;
                        if (w_phase_inc == '0) begin
                            if (w_bp_hit) begin
                                w_state_nxt = S_BREAK;
                            end else begin
                                w_ce_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (w_press[1]) begin
                        // Resume: mask the breakpoint so we step off this PC
                        w_state_nxt = S_RUN;
                        w_phase_nxt = '0;
                        w_mask_nxt  = 1'b1;
                        w_ce_nxt    = 1'b1;
                    end else if (w_press[0]) begin
                        w_state_nxt = S_STEP;
                        w_ce_nxt    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_RESET;
                    w_hold_nxt  = HOLD_VAL;
                    w_rst_nxt   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_phase    <= '0;
            r_hold     <= HOLD_VAL;
            r_bp_mask  <= 1'b0;
            r_cpu_ce   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_step_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_hold    <= w_hold_nxt;
            r_bp_mask <= w_mask_nxt;
            r_cpu_ce  <= w_ce_nxt;
            r_cpu_rst <= w_rst_nxt;
            if (w_cnt_clr) begin
                r_step_cnt <= '0;
            end else if (w_ce_nxt) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign cpu_ce     = r_cpu_ce;
    assign cpu_rst    = r_cpu_rst;
    assign running    = (r_state == S_RUN);
    assign halted_bp  = (r_state == S_BREAK);
    assign step_cnt   = r_step_cnt;
    assign ctrl_state = r_state;

endmodule
